// File: rtl/peribus_pkg.sv
// Shared Peribus widths and arbiter state encoding.
// Imported by the arbiter and its round-robin picker.
package peribus_pkg;

  localparam int PERIBUS_ADDR_W = 8;
  localparam int PERIBUS_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    ACK
  } peribus_arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request after 'last'.
// Kept generic so interrupt and DMA schedulers can reuse it.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          valid
);

  // scan last+1, last+2, ... wrapping; first hit wins
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!valid && req[IW'(idx)]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peribus_arbiter.sv
// Round-robin arbiter sharing one Peribus controller port.
// Each transaction runs IDLE -> STROBE -> WAIT -> ACK.
module peribus_arbiter
  import peribus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NUM_MASTERS-1:0]      m_req,
  input  logic [NUM_MASTERS-1:0]      m_we,
  input  logic [NUM_MASTERS*8-1:0]    m_addr,
  input  logic [NUM_MASTERS*16-1:0]   m_wdata,
  output logic [NUM_MASTERS-1:0]      m_ack,
  output logic [15:0]                 m_rdata,
  output logic [NUM_MASTERS-1:0]      grant,
  output logic                        busy,
  output logic [7:0]                  bus_addr,
  output logic [15:0]                 bus_write_data,
  output logic                        bus_write_enable,
  output logic                        bus_read_enable,
  input  logic [15:0]                 bus_read_data
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int AW = PERIBUS_ADDR_W;
  localparam int DW = PERIBUS_DATA_W;

  peribus_arb_state_t state_q, state_d;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [IW-1:0]          last_q, last_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          wdata_q, wdata_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic                   we_q, we_d;
  logic                   wen_q, wen_d;
  logic                   ren_q, ren_d;
  logic                   busy_q, busy_d;
  logic [3:0]             cnt_q, cnt_d;

  logic [IW-1:0] win;
  logic          win_vld;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req    (m_req),
    .last   (last_q),
    .winner (win),
    .valid  (win_vld)
  );

  // mux the winning master's address, data and direction
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (IW'(i) == win) begin
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*DW +: DW];
        sel_we    = m_we[i];
      end
    end
  end

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_vld) begin
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = sel_we;
          wen_d   = sel_we;
          ren_d   = !sel_we;
          grant_d = NUM_MASTERS'(1) << win;
          last_d  = win;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = 4'(WAIT_STATES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = bus_read_data;
          end
          ack_d   = grant_q;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_ack            = ack_q;
  assign m_rdata          = rdata_q;
  assign grant            = grant_q;
  assign busy             = busy_q;
  assign bus_addr         = addr_q;
  assign bus_write_data   = wdata_q;
  assign bus_write_enable = wen_q;
  assign bus_read_enable  = ren_q;

endmodule

// File: tb/tb_peribus_arbiter.sv
// Directed bench for peribus_arbiter.
// Two instances: WAIT_STATES=1 (a_*) and WAIT_STATES=3 (b_*).
module tb_peribus_arbiter;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [1:0]  a_req = '0, a_we = '0;
  logic [15:0] a_addr = '0;
  logic [31:0] a_wdata = '0;
  logic [15:0] a_rd = '0;
  logic [1:0]  a_ack, a_grant;
  logic [15:0] a_rdata, a_bwd;
  logic [7:0]  a_baddr;
  logic        a_busy, a_wen, a_ren;

  logic [1:0]  b_req = '0, b_we = '0;
  logic [15:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [15:0] b_rd = '0;
  logic [1:0]  b_ack, b_grant;
  logic [15:0] b_rdata, b_bwd;
  logic [7:0]  b_baddr;
  logic        b_busy, b_wen, b_ren;

  int total = 0;
  int bad   = 0;

  peribus_arbiter #(.NUM_MASTERS(2), .WAIT_STATES(1)) dut_a (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .m_req            (a_req),
    .m_we             (a_we),
    .m_addr           (a_addr),
    .m_wdata          (a_wdata),
    .m_ack            (a_ack),
    .m_rdata          (a_rdata),
    .grant            (a_grant),
    .busy             (a_busy),
    .bus_addr         (a_baddr),
    .bus_write_data   (a_bwd),
    .bus_write_enable (a_wen),
    .bus_read_enable  (a_ren),
    .bus_read_data    (a_rd)
  );

  peribus_arbiter #(.NUM_MASTERS(2), .WAIT_STATES(3)) dut_b (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .m_req            (b_req),
    .m_we             (b_we),
    .m_addr           (b_addr),
    .m_wdata          (b_wdata),
    .m_ack            (b_ack),
    .m_rdata          (b_rdata),
    .grant            (b_grant),
    .busy             (b_busy),
    .bus_addr         (b_baddr),
    .bus_write_data   (b_bwd),
    .bus_write_enable (b_wen),
    .bus_read_enable  (b_ren),
    .bus_read_data    (b_rd)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // run one dut_a transaction; acked master drops its request
  task automatic run_a(output int lat, output int rcnt,
                       output int wcnt, output logic [1:0] ackv,
                       output logic [1:0] sg, output logic [7:0] sa,
                       output logic [15:0] sw);
    lat = -1; rcnt = 0; wcnt = 0;
    ackv = '0; sg = '0; sa = '0; sw = '0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (a_ren) rcnt++;
      if (a_wen) wcnt++;
      if (a_wen || a_ren) begin
        sa = a_baddr;
        sw = a_bwd;
      end
      if (sg == 2'b00) sg = a_grant;
      if (a_ack != 2'b00) begin
        lat  = n;
        ackv = a_ack;
        a_req = a_req & ~a_ack;
        break;
      end
    end
  endtask

  int          lat, rc, wc;
  logic [1:0]  ak, sg;
  logic [7:0]  sa;
  logic [15:0] sw;
  logic [1:0]  gseq [4];
  int          ack0_at, ack1_at, strobes_m0;
  logic [1:0]  g_at4, g_at5;
  int          b_lat;
  int          ack_seen;

  initial begin
    // reset
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ack",   32'(a_ack), 32'h0);
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_busy",  32'(a_busy), 32'h0);
    chk("rst_en",    32'({a_wen, a_ren}), 32'h0);
    chk("rst_addr",  32'(a_baddr), 32'h0);
    chk("rst_wd",    32'(a_bwd), 32'h0);
    chk("rst_rdata", 32'(a_rdata), 32'h0);

    // single read by master 0
    a_rd   = 16'hBEEF;
    a_we   = 2'b00;
    a_addr = 16'h0002;
    a_req  = 2'b01;
    run_a(lat, rc, wc, ak, sg, sa, sw);
    chk("rd_lat",   32'(lat), 32'd3);
    chk("rd_rcnt",  32'(rc), 32'd1);
    chk("rd_wcnt",  32'(wc), 32'd0);
    chk("rd_ack",   32'(ak), 32'h1);
    chk("rd_grant", 32'(sg), 32'h1);
    chk("rd_addr",  32'(sa), 32'h02);
    chk("rd_data",  32'(a_rdata), 32'hBEEF);
    tick();
    chk("rd_idle_busy", 32'(a_busy), 32'h0);

    // single write by master 1; controller drives junk
    a_rd    = 16'h5555;
    a_we    = 2'b10;
    a_addr  = 16'h0500;
    a_wdata = 32'h1234_0000;
    a_req   = 2'b10;
    run_a(lat, rc, wc, ak, sg, sa, sw);
    chk("wr_lat",   32'(lat), 32'd3);
    chk("wr_wcnt",  32'(wc), 32'd1);
    chk("wr_rcnt",  32'(rc), 32'd0);
    chk("wr_ack",   32'(ak), 32'h2);
    chk("wr_addr",  32'(sa), 32'h05);
    chk("wr_wdata", 32'(sw), 32'h1234);
    chk("wr_rdata", 32'(a_rdata), 32'hBEEF);

    // contention after a fresh reset
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_we   = 2'b00;
    a_addr = 16'h1110;
    a_req  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      run_a(lat, rc, wc, ak, sg, sa, sw);
      gseq[t] = ak;
      if (t == 1) chk("cont_thru", 32'(lat), 32'd4);
      a_req = (t == 3) ? 2'b00 : 2'b11;
    end
    chk("cont_g0", 32'(gseq[0]), 32'h1);
    chk("cont_g1", 32'(gseq[1]), 32'h2);
    chk("cont_g2", 32'(gseq[2]), 32'h1);
    chk("cont_g3", 32'(gseq[3]), 32'h2);
    tick();

    // wait states on dut_b; data valid only in last WAIT cycle
    b_rd   = 16'h1111;
    b_we   = 2'b00;
    b_addr = 16'h0009;
    b_req  = 2'b01;
    b_lat  = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 4) b_rd = 16'hA5A5;
      if (b_ack != 2'b00) begin
        b_lat = n;
        b_req = 2'b00;
        break;
      end
    end
    chk("ws_lat",   32'(b_lat), 32'd5);
    chk("ws_ack",   32'(b_ack), 32'h1);
    chk("ws_rdata", 32'(b_rdata), 32'hA5A5);
    tick();

    // reset mid-WAIT aborts master 0's transaction
    a_we   = 2'b00;
    a_addr = 16'h0003;
    a_req  = 2'b01;
    tick();
    tick();
    chk("abort_busy_pre", 32'(a_busy), 32'h1);
    reset = 1'b1;
    a_req = 2'b00;
    tick();
    reset = 1'b0;
    chk("abort_ack",   32'(a_ack), 32'h0);
    chk("abort_grant", 32'(a_grant), 32'h0);
    chk("abort_en",    32'({a_wen, a_ren}), 32'h0);
    ack_seen = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (a_ack != 2'b00) ack_seen++;
    end
    chk("abort_noack", 32'(ack_seen), 32'd0);
    a_req = 2'b11;
    run_a(lat, rc, wc, ak, sg, sa, sw);
    chk("abort_next", 32'(ak), 32'h1);
    a_req = 2'b00;
    tick();

    // late request from master 1 during master 0's STROBE
    a_we    = 2'b10;
    a_addr  = 16'h0704;
    a_wdata = 32'h00AA_0000;
    a_req   = 2'b01;
    ack0_at = -1;
    ack1_at = -1;
    strobes_m0 = 0;
    g_at4 = 2'bxx;
    g_at5 = 2'bxx;
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 1) a_req = 2'b11;
      if (n <= 3 && (a_wen || a_ren)) strobes_m0++;
      if (n == 4) g_at4 = a_grant;
      if (n == 5) g_at5 = a_grant;
      if (a_ack == 2'b01 && ack0_at < 0) begin
        ack0_at = n;
        a_req = a_req & 2'b10;
      end
      if (a_ack == 2'b10) begin
        ack1_at = n;
        a_req = 2'b00;
        break;
      end
    end
    chk("late_ack0",    32'(ack0_at), 32'd3);
    chk("late_strobes", 32'(strobes_m0), 32'd1);
    chk("late_idle_g",  32'(g_at4), 32'h0);
    chk("late_grant1",  32'(g_at5), 32'h2);
    chk("late_ack1",    32'(ack1_at), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peribus_arbiter.md
Name: peribus_arbiter

Overview:
- Shares the single Peribus controller port between NUM_MASTERS requesters, for example the CPU load/store unit and a DMA/debug engine.
- Selects one requester per transaction using round-robin priority.
- Sequences each transaction through a fixed strobe/wait/capture cycle and returns a one-cycle ack with read data to the winner.
- Sits between the masters and the Peribus controller's addr, write_data, write_enable, read_enable and read_data pins.

Parameters:
- NUM_MASTERS, 2: number of requesting masters (2..8).
- WAIT_STATES, 1: cycles between the end of the strobe and read-data capture (1..15).

Ports:
- CLOCK_50  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NUM_MASTERS  per-master request level; held until that master's ack.
- m_we  in  NUM_MASTERS  per-master direction; 1 = write, 0 = read.
- m_addr  in  NUM_MASTERS*8  flattened per-master addresses; master i uses bits [8i+7:8i].
- m_wdata  in  NUM_MASTERS*16  flattened per-master write data; master i uses bits [16i+15:16i].
- m_ack  out  NUM_MASTERS  one-hot, one-cycle completion pulse.
- m_rdata  out  16  read data from the last completed read; shared by all masters.
- grant  out  NUM_MASTERS  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in every state except IDLE.
- bus_addr  out  8  to the Peribus controller's addr.
- bus_write_data  out  16  to the controller's write_data.
- bus_write_enable  out  1  to the controller's write_enable.
- bus_read_enable  out  1  to the controller's read_enable.
- bus_read_data  in  16  from the controller's read_data.

Behaviour:
- Reset (synchronous, active-high). On the edge where reset is high:
  - state = IDLE.
  - m_ack, grant, busy, bus_write_enable, bus_read_enable = 0.
  - bus_addr, bus_write_data, m_rdata = 0.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 has top priority first.
- Reset asserted mid-transaction aborts it. There is no ack, the strobe drops on the next edge, and the masters must re-request.
- States: IDLE, STROBE, WAIT, ACK. All outputs are registered.
- IDLE:
  - If m_req is nonzero, pick the winner w: the first asserted request scanning last+1, last+2, ... modulo NUM_MASTERS.
  - Latch m_addr[w], m_wdata[w] and m_we[w] into bus_addr, bus_write_data and an internal we register.
  - Set grant = 1<<w and last = w, then go to STROBE.
  - Otherwise stay in IDLE with grant = 0.
- STROBE (exactly 1 cycle):
  - bus_write_enable = we, bus_read_enable = !we.
  - Load wait counter = WAIT_STATES-1, then go to WAIT.
- WAIT (WAIT_STATES cycles):
  - Both enables are 0; bus_addr and bus_write_data are held.
  - Counter decrements. On the counter=0 cycle:
    - For a read, capture bus_read_data into m_rdata at that edge. For a write, m_rdata is unchanged.
    - Go to ACK.
- ACK (1 cycle):
  - m_ack = grant and m_rdata is valid. Go to IDLE; grant clears on entry to IDLE.
- Latency: m_req sampled in IDLE to m_ack high is WAIT_STATES+2 cycles. Back-to-back throughput is one transaction per WAIT_STATES+3 cycles.
- Master handshake rule:
  - The master deasserts m_req at the edge ending its ack cycle, so the IDLE that follows sees it low.
  - A request still high in that IDLE is treated as a new transaction.
- Requests arriving in STROBE, WAIT or ACK are ignored until IDLE. Master inputs are not re-sampled during a transaction.
- Simultaneous requests are resolved by round-robin only. No master can win twice in a row while another is requesting.
- bus_write_enable and bus_read_enable are never high together, and never high outside STROBE.
- Unmapped addresses still complete normally; m_rdata then holds whatever the controller returned.

Decomposition:
- peribus_pkg holds:
  - PERIBUS_ADDR_W = 8 and PERIBUS_DATA_W = 16.
  - typedef enum logic [1:0] peribus_arb_state_t {IDLE, STROBE, WAIT, ACK}.
- Sub-module rr_picker: purely combinational.
  - Inputs: req[N], last index.
  - Outputs: winner index and a valid flag.
  - Reusable by later interrupt and DMA schedulers.

Test Plan:
- Reset and single read:
  - Stimulus: reset for 2 cycles; master 0 reads addr 0x02; bus_read_data = 0xBEEF.
  - Response: bus_read_enable high for exactly 1 cycle; m_ack = 2'b01 exactly 3 cycles after the request is sampled; m_rdata = 0xBEEF.
- Single write:
  - Stimulus: master 1 writes 0x1234 to addr 0x05.
  - Response: bus_addr = 0x05 and bus_write_data = 0x1234 during STROBE; bus_write_enable pulses once; bus_read_enable stays 0; m_ack = 2'b10; m_rdata unchanged.
- Contention:
  - Stimulus: both masters request continuously for 4 transactions.
  - Response: grants alternate 01, 10, 01, 10, starting with master 0 after reset.
- Wait states:
  - Stimulus: WAIT_STATES = 3; bus_read_data changes to 0xA5A5 only on the last WAIT cycle.
  - Response: ack arrives 5 cycles after the request; m_rdata = 0xA5A5.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT.
  - Response: no m_ack; all enables and grant are 0 on the next edge; master 0 wins the next contention.
- Late request:
  - Stimulus: master 1 raises m_req while master 0 is in STROBE.
  - Response: master 1 is granted in the IDLE immediately after master 0's ack; no bus strobe overlaps master 0's transaction.
